twiddle_seq: RTL and testbench

- Parametrised successor to the fixed 8-entry Q8.8 twiddle table. Generates the radix-2 DIT twiddle stream W_N^k = cos(2πk/N) - j·sin(2πk/N) for one FFT stage per start command, one twiddle per butterfly.
- Sits between the FFT stage controller and the butterfly datapath.
- Stores only a quarter-wave ROM. Supports forward and inverse (conjugate) mode, and output backpressure.

---
 rtl/twiddle_seq.sv | 209 ++++++++++++++++++++
 tb/tb_twiddle_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_seq
// Purpose  : Radix-2 DIT twiddle generator. For each start command it emits
//            the N/2 twiddles W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) of one
//            FFT stage, one per butterfly. Only a quarter-wave cosine ROM is
//            stored; the rest of the circle is obtained by folding. Supports
//            conjugate (inverse) output and ready/valid backpressure.
// Ports    : clk, rst_n          clock, async active-low reset
//            start, stage,       stage request (sampled only while idle)
//            inverse
//            busy                stage in progress
//            out_valid/out_ready twiddle handshake
//            out_w               {re, im}, two's complement, FRAC fraction bits
//            out_k, out_last     exponent k, final twiddle of the stage
//            done                one-cycle pulse after the final handshake
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_seq #(
  parameter int LOG2N = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(LOG2N)-1:0] stage,
  input  logic                     inverse,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*DW-1:0]          out_w,
  output logic [LOG2N-1:0]         out_k,
  output logic                     out_last,
  output logic                     done
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int QTR  = N / 4;
  localparam int IW   = LOG2N - 1;        // butterfly index 0..N/2-1
  localparam int SW   = $clog2(LOG2N);
  localparam int RW   = FRAC + 1;         // ROM magnitude, 0..2^FRAC
  localparam int AW   = LOG2N - 1;        // ROM address, 0..N/4

  // Fixed-point constants for the elaboration-time cosine (Q30).
  localparam longint ONE_Q30 = 64'sd1 << 30;
  localparam longint PI_Q30  = 64'sd3373259426;

  // Round-half-away of 2^FRAC*cos(2*pi*r/N) for 0 <= r <= N/4, computed
  // with an integer Taylor series so no real arithmetic is needed. Over
  // [0, pi/2] twelve terms leave an error far below one output LSB.
  function automatic logic [RW-1:0] cos_q(input int r);
    longint x, x2, term, sum, scaled;
    x    = (PI_Q30 * longint'(r)) >>> (LOG2N - 1);
    x2   = (x * x) >>> 30;
    term = ONE_Q30;
    sum  = ONE_Q30;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    if (r == 0) return RW'(1) << FRAC;
    if (r == QTR) return '0;
    if (sum <= 0) return '0;
    scaled = ((sum <<< FRAC) + (ONE_Q30 >>> 1)) >>> 30;
    return RW'(scaled);
  endfunction

  // Quarter-wave ROM, one constant per entry.
  logic [RW-1:0] rom [0:QTR];
  for (genvar g = 0; g <= QTR; g++) begin : g_rom
    localparam logic [RW-1:0] ROM_VAL = cos_q(g);
    assign rom[g] = ROM_VAL;
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_stage;
  logic            r_inv;
  logic [IW-1:0]   r_i;

  // Pipeline stage 1: decoded exponent and ROM addresses.
  logic             r1_valid;
  logic             r1_last;
  logic [LOG2N-1:0] r1_k;
  logic [AW-1:0]    r1_ra;
  logic [AW-1:0]    r1_rb;

  logic             w_en;
  logic             w_issue;
  logic [SW-1:0]    w_stage_in;
  logic [SW-1:0]    w_sel_stage;
  logic [IW-1:0]    w_idx;
  logic [LOG2N-1:0] w_mask;
  logic [LOG2N-1:0] w_k;
  logic [AW-1:0]    w_ra;
  logic signed [DW-1:0] w_cos, w_sin, w_re, w_im;

  // Whole pipeline advances together; a held output freezes everything.
  assign w_en = !out_valid || out_ready;

  // Out-of-range stage requests collapse onto the last stage.
  assign w_stage_in = (int'(stage) >= LOG2N) ? SW'(LOG2N - 1) : stage;

  // Index decode. Index 0 is issued in the same cycle start is accepted,
  // using the live stage input, so the first twiddle appears two cycles on.
  always_comb begin
    w_issue     = 1'b0;
    w_sel_stage = r_stage;
    w_idx       = r_i;
    if (r_state == S_IDLE) begin
      w_issue     = start;
      w_sel_stage = w_stage_in;
      w_idx       = '0;
    end else if (r_state == S_RUN) begin
      w_issue = 1'b1;
    end
    w_mask = (LOG2N'(1) << w_sel_stage) - LOG2N'(1);
    w_k    = (LOG2N'(w_idx) & w_mask) << (IW - int'(w_sel_stage));
    w_ra   = AW'(w_k[LOG2N-3:0]);
  end

  // Fold the quarter-wave lookup onto the half circle k < N/2.
  always_comb begin
    w_cos = DW'(rom[r1_ra]);
    w_sin = DW'(rom[r1_rb]);
    if (!r1_k[LOG2N-2]) begin
      w_re = w_cos;
      w_im = -w_sin;
    end else begin
      w_re = -w_sin;
      w_im = -w_cos;
    end
    if (r_inv) w_im = -w_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_inv     <= 1'b0;
      r_i       <= '0;
      r1_valid  <= 1'b0;
      r1_last   <= 1'b0;
      r1_k      <= '0;
      r1_ra     <= '0;
      r1_rb     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_w     <= '0;
      out_k     <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_en) begin
        // Output register: ROM read + sign applied.
        out_valid <= r1_valid;
        out_last  <= r1_valid & r1_last;
        if (r1_valid) begin
          out_w <= {w_re, w_im};
          out_k <= r1_k;
        end

        // Decode register.
        r1_valid <= w_issue;
        if (w_issue) begin
          r1_k    <= w_k;
          r1_ra   <= w_ra;
          r1_rb   <= AW'(QTR) - w_ra;
          r1_last <= (w_idx == IW'(HALF - 1));
        end

        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_RUN;
              r_stage <= w_stage_in;
              r_inv   <= inverse;
              r_i     <= IW'(1);
              busy    <= 1'b1;
            end
          end
          S_RUN: begin
            r_i <= r_i + 1'b1;
            if (r_i == IW'(HALF - 1)) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            // w_en with out_valid high implies out_ready: this is the handshake.
            if (out_valid && out_last) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_seq
// Purpose  : Directed self-checking bench for twiddle_seq. One instance uses
//            the default N=16 Q8.8 configuration, a second one N=1024 Q?.14.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, inverse, out_ready;
  logic [1:0]  stage;
  logic        busy, out_valid, out_last, done;
  logic [31:0] out_w;
  logic [3:0]  out_k;

  logic        start10, inverse10, ready10;
  logic [3:0]  stage10;
  logic        busy10, valid10, last10, done10;
  logic [35:0] w10;
  logic [9:0]  k10;

  int checks = 0;
  int errors = 0;

  int RE_T [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int IM_T [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  twiddle_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .out_k(out_k), .out_last(out_last), .done(done)
  );

  twiddle_seq #(.LOG2N(10), .DW(18), .FRAC(14)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .stage(stage10), .inverse(inverse10),
    .busy(busy10), .out_valid(valid10), .out_ready(ready10), .out_w(w10),
    .out_k(k10), .out_last(last10), .done(done10)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_stage(input int s, input bit inv);
    @(negedge clk);
    stage   = 2'(s);
    inverse = inv;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_valid_cycle1", out_valid, 0);
  endtask

  // Called at the negedge of cycle 1 (start accepted at the preceding edge).
  task automatic collect(input int s, input bit inv, input bit rnd,
                         input bit pulse_start, input bit timing);
    int idx, cyc, first_v, last_hs, ek, eim;
    logic [31:0] prev_w;
    logic [3:0]  prev_k;
    logic        prev_last;
    bit          stalled;
    idx = 0; cyc = 1; first_v = -1; last_hs = -1; stalled = 0;
    prev_w = '0; prev_k = '0; prev_last = 1'b0;
    while (idx < 8 && cyc < 200) begin
      if (stalled) begin
        check("stall_w", out_w, prev_w);
        check("stall_k", out_k, prev_k);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pulse_start && (cyc == 4);
      if (start) stage = 2'd0;
      if (out_valid && out_ready) begin
        ek  = (idx % (1 << s)) << (3 - s);
        eim = inv ? -IM_T[ek] : IM_T[ek];
        check($sformatf("k[%0d]", idx), out_k, ek);
        check($sformatf("re[%0d]", idx), $signed(out_w[31:16]), RE_T[ek]);
        check($sformatf("im[%0d]", idx), $signed(out_w[15:0]), eim);
        check($sformatf("last[%0d]", idx), out_last, (idx == 7));
        if (idx == 7) last_hs = cyc;
        idx++;
        stalled = 0;
      end else begin
        stalled   = out_valid;
        prev_w    = out_w;
        prev_k    = out_k;
        prev_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("count", idx, 8);
    if (timing) begin
      check("first_valid_cycle", first_v, 2);
      check("last_hs_cycle", last_hs, 9);
    end
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("valid_after", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int  hs, cyc, n10;
    bit  done_seen, kseq_ok, last_ok;

    rst_n = 1'b0; start = 1'b0; stage = '0; inverse = 1'b0; out_ready = 1'b0;
    start10 = 1'b0; stage10 = '0; inverse10 = 1'b0; ready10 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_w", out_w, 0);
    check("rst_k", out_k, 0);
    rst_n = 1'b1;

    // Full stage, forward
    start_stage(3, 0); collect(3, 0, 0, 0, 1);
    // Early stages
    start_stage(1, 0); collect(1, 0, 0, 0, 1);
    start_stage(0, 0); collect(0, 0, 0, 0, 1);
    // Inverse
    start_stage(3, 1); collect(3, 1, 0, 0, 1);
    // Random backpressure with an ignored start while busy
    start_stage(3, 0); collect(3, 0, 1, 1, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_restart", out_valid | busy, 0);
    end

    // Reset mid-stage after three handshakes
    start_stage(3, 0);
    out_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 20) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    check("rst_hs_count", hs, 3);
    check("rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_w", out_w, 0);
    check("midrst_k", out_k, 0);
    check("midrst_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      done_seen = done_seen | done | out_valid;
    end
    check("no_done_after_rst", done_seen, 0);
    start_stage(3, 0); collect(3, 0, 0, 0, 1);

    // N=1024, Q.14, last stage
    @(negedge clk);
    stage10 = 4'd9; inverse10 = 1'b0; start10 = 1'b1; ready10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    n10 = 0; cyc = 0; kseq_ok = 1; last_ok = 1;
    while (n10 < 512 && cyc < 700) begin
      if (valid10) begin
        if (k10 !== 10'(n10)) kseq_ok = 0;
        if (last10 !== (n10 == 511)) last_ok = 0;
        case (k10)
          10'd0:   begin check("n10_k0_re", $signed(w10[35:18]), 16384);
                         check("n10_k0_im", $signed(w10[17:0]), 0); end
          10'd1:   begin check("n10_k1_re", $signed(w10[35:18]), 16384);
                         check("n10_k1_im", $signed(w10[17:0]), -101); end
          10'd64:  begin check("n10_k64_re", $signed(w10[35:18]), 15137);
                         check("n10_k64_im", $signed(w10[17:0]), -6270); end
          10'd128: begin check("n10_k128_re", $signed(w10[35:18]), 11585);
                         check("n10_k128_im", $signed(w10[17:0]), -11585); end
          10'd192: begin check("n10_k192_re", $signed(w10[35:18]), 6270);
                         check("n10_k192_im", $signed(w10[17:0]), -15137); end
          10'd256: begin check("n10_k256_re", $signed(w10[35:18]), 0);
                         check("n10_k256_im", $signed(w10[17:0]), -16384); end
          10'd384: begin check("n10_k384_re", $signed(w10[35:18]), -11585);
                         check("n10_k384_im", $signed(w10[17:0]), -11585); end
          10'd511: begin check("n10_k511_re", $signed(w10[35:18]), -16384);
                         check("n10_k511_im", $signed(w10[17:0]), -101); end
          default: ;
        endcase
        n10++;
      end
      @(negedge clk);
      cyc++;
    end
    check("n10_count", n10, 512);
    check("n10_kseq", kseq_ok, 1);
    check("n10_last", last_ok, 1);
    check("n10_done", done10, 1);
    check("n10_busy_fall", busy10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
